// File: rtl/pipelined_addsub.sv
// ---------------------------------------------------------------------------
// pipelined_addsub
//
// Pipelined add/subtract unit for the EX stage. The operand width is cut into
// STAGES equal chunks of CHUNK = WIDTH/STAGES bits. Each stage ripples one
// chunk and registers the carry for the next stage. The operand bits that no
// stage has consumed yet travel alongside in delay registers, and the result
// chunks already produced are carried forward.
//
// Operation select (op):
//   00  a + b
//   01  a - b             (a + ~b + 1)
//   10  a + b + cin
//   11  a - b - !cin      (a + ~b + cin)
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      operands valid; transfer when in_valid & in_ready
//   in_ready   out  1      unit can accept this cycle (combinational)
//   a, b       in   WIDTH  operands
//   cin        in   1      carry/borrow input, used by op 10 and 11 only
//   op         in   2      operation select, see above
//   out_valid  out  1      result valid (registered)
//   out_ready  in   1      downstream accepts; transfer when out_valid & out_ready
//   sum        out  WIDTH  result modulo 2^WIDTH (registered)
//   cout       out  1      carry out of the MSB (for subtract: 1 = no borrow)
//   ovf        out  1      signed two's-complement overflow
//   zero       out  1      sum == 0 over the full width
//
// Latency is STAGES cycles and throughput is one op per cycle. The whole
// pipeline advances together whenever the output register is empty or is
// being drained. Otherwise every register, including the outputs, holds.
// ---------------------------------------------------------------------------
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be a positive multiple of STAGES");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // One global advance signal: a full output register that is not being
  // drained freezes everything upstream as well.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Subtraction is folded into an add of the inverted operand, so every
  // stage only ever sees a + B' + carry.
  assign b_eff = op[0] ? ~b : b;
  assign c0    = op[1] ? cin : op[0];

  // -------------------------------------------------------------------------
  // Stage valid bits (control only, the only state under reset besides the
  // output register).
  // -------------------------------------------------------------------------
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;

  always_comb begin
    vld_d = vld_q;
    if (adv) begin
      vld_d[0] = in_valid;
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i] = vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];

  // -------------------------------------------------------------------------
  // Datapath stages. Stage k owns bits [LO +: CHUNK]. Its inputs are the
  // not-yet-consumed operand bits [WIDTH-1:LO], the carry from stage k-1 and
  // the result bits [LO-1:0] already produced by stages 0..k-1.
  // -------------------------------------------------------------------------
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * CHUNK;
    localparam int HI = LO + CHUNK;

    logic [WIDTH-1:LO] up_a;
    logic [WIDTH-1:LO] up_b;
    logic              carry_in;
    logic              vld_in;
    logic              load;
    logic [CHUNK-1:0]  chunk_s;
    logic              carry_s;
    logic [HI-1:0]     res_d;

    if (k == 0) begin : g_head
      assign up_a     = a;
      assign up_b     = b_eff;
      assign carry_in = c0;
      assign vld_in   = in_valid;
      assign res_d    = chunk_s;
    end else begin : g_tail
      assign up_a     = g_st[k-1].g_body.a_q;
      assign up_b     = g_st[k-1].g_body.b_q;
      assign carry_in = g_st[k-1].g_body.cy_q;
      assign vld_in   = vld_q[k-1];
      assign res_d    = {chunk_s, g_st[k-1].g_body.res_q};
    end

    assign {carry_s, chunk_s} = {1'b0, up_a[HI-1:LO]} + {1'b0, up_b[HI-1:LO]}
                              + (CHUNK+1)'(carry_in);

    // Registers only load real ops, so a bubble never overwrites the last
    // valid result held at the outputs.
    assign load = adv && vld_in;

    if (k < STAGES-1) begin : g_body
      // ---- stage k -> stage k+1 boundary ----
      logic [WIDTH-1:HI] a_q;
      logic [WIDTH-1:HI] b_q;
      logic [HI-1:0]     res_q;
      logic              cy_q;

      always_ff @(posedge clk) begin
        if (load) begin
          a_q   <= up_a[WIDTH-1:HI];
          b_q   <= up_b[WIDTH-1:HI];
          res_q <= res_d;
          cy_q  <= carry_s;
        end
      end
    end else begin : g_out
      // ---- final stage -> output register boundary ----
      // The top chunk holds the operand sign bits, so overflow is judged on
      // the delayed A and B' rather than on whatever is on the inputs now.
      always_ff @(posedge clk) begin
        if (rst) begin
          sum  <= '0;
          cout <= 1'b0;
          ovf  <= 1'b0;
          zero <= 1'b0;
        end else if (load) begin
          sum  <= res_d;
          cout <= carry_s;
          ovf  <= (up_a[WIDTH-1] == up_b[WIDTH-1]) &&
                  (chunk_s[CHUNK-1] != up_a[WIDTH-1]);
          zero <= ~|res_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// ---------------------------------------------------------------------------
// tb_pipelined_addsub
//
// Three instances (STAGES = 4, 1, 8; WIDTH = 32) share the operand inputs and
// reset; each has its own out_ready. Every instance has a scoreboard queue of
// expected results built from plain 33-bit / 64-bit arithmetic, each entry
// tagged with the cycle it is due, so latency, ordering, stall behaviour and
// output stability are all checked against the model.
// ---------------------------------------------------------------------------
module tb_pipelined_addsub;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [1:0]  op;
  logic        out_ready   [3];
  logic        in_ready_w  [3];
  logic        out_valid_w [3];
  logic [31:0] sum_w       [3];
  logic        cout_w      [3];
  logic        ovf_w       [3];
  logic        zero_w      [3];
  int          qlen        [3];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: result = a + B' + C0, overflow from the true signed sum.
  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                 input logic cv, input logic [1:0] opv);
    exp_t        e;
    logic [31:0] bp;
    logic        c0;
    logic [32:0] full;
    longint      s;
    bp     = opv[0] ? ~bv : bv;
    c0     = opv[1] ? cv : opv[0];
    full   = {1'b0, av} + {1'b0, bp} + 33'(c0);
    s      = longint'($signed(av)) + longint'($signed(bp)) + longint'(c0);
    e.sum  = full[31:0];
    e.cout = full[32];
    e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    e.zero = (full[31:0] == 32'd0);
    e.due  = 0;
    return e;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int S = (g == 0) ? 4 : ((g == 1) ? 1 : 8);

    pipelined_addsub #(.WIDTH(32), .STAGES(S)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[g]),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .op        (op),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready[g]),
      .sum       (sum_w[g]),
      .cout      (cout_w[g]),
      .ovf       (ovf_w[g]),
      .zero      (zero_w[g])
    );

    exp_t q[$];
    exp_t e;

    always @(negedge clk) begin
      if (rst) begin
        q.delete();
      end else begin
        check($sformatf("S%0d in_ready", S), in_ready_w[g],
              !out_valid_w[g] || out_ready[g]);
        if (out_valid_w[g]) begin
          if (q.size() == 0) begin
            check($sformatf("S%0d unexpected out_valid", S), out_valid_w[g], 1'b0);
          end else begin
            check($sformatf("S%0d sum", S),  sum_w[g],  q[0].sum);
            check($sformatf("S%0d cout", S), cout_w[g], q[0].cout);
            check($sformatf("S%0d ovf", S),  ovf_w[g],  q[0].ovf);
            check($sformatf("S%0d zero", S), zero_w[g], q[0].zero);
            check($sformatf("S%0d latency cycle", S), cyc, q[0].due);
            if (out_ready[g]) begin
              void'(q.pop_front());
            end else begin
              for (int i = 0; i < q.size(); i++) q[i].due = q[i].due + 1;
            end
          end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
          check($sformatf("S%0d result late", S), out_valid_w[g], 1'b1);
          void'(q.pop_front());
        end
        if (in_valid && in_ready_w[g]) begin
          e     = model(a, b, cin, op);
          e.due = cyc + S;
          q.push_back(e);
        end
      end
      qlen[g] = q.size();
    end
  end

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Single op on an idle pipeline, all outputs ready; each instance's first
  // out_valid must carry the literal expected values.
  task automatic directed(input string name, input logic [31:0] av, input logic [31:0] bv,
                          input logic cv, input logic [1:0] opv, input logic [31:0] es,
                          input logic ec, input logic eo, input logic ez);
    bit seen [3];
    for (int g = 0; g < 3; g++) seen[g] = 1'b0;
    @(posedge clk); #1;
    for (int g = 0; g < 3; g++) out_ready[g] = 1'b1;
    in_valid = 1'b1; a = av; b = bv; cin = cv; op = opv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (out_valid_w[g] && !seen[g]) begin
          seen[g] = 1'b1;
          check($sformatf("%s[%0d] sum", name, g),  sum_w[g],  es);
          check($sformatf("%s[%0d] cout", name, g), cout_w[g], ec);
          check($sformatf("%s[%0d] ovf", name, g),  ovf_w[g],  eo);
          check($sformatf("%s[%0d] zero", name, g), zero_w[g], ez);
        end
      end
    end
    for (int g = 0; g < 3; g++) check($sformatf("%s[%0d] completed", name, g), seen[g], 1'b1);
  endtask

  initial begin
    int sent;
    int it;

    // T1: reset held two cycles while in_valid is high
    rst = 1'b1; in_valid = 1'b1; a = 32'h1234_5678; b = 32'h1; cin = 1'b0; op = 2'b00;
    for (int g = 0; g < 3; g++) out_ready[g] = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("reset[%0d] out_valid", g), out_valid_w[g], 1'b0);
      check($sformatf("reset[%0d] sum", g),       sum_w[g],       32'h0);
      check($sformatf("reset[%0d] flags", g),
            {cout_w[g], ovf_w[g], zero_w[g]}, 3'b000);
    end
    rst = 1'b0; in_valid = 1'b0;
    for (int g = 0; g < 3; g++) out_ready[g] = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) check($sformatf("post-reset[%0d] in_ready", g), in_ready_w[g], 1'b1);

    // T2-T4 and a few extra boundaries, on all three depths
    directed("add carry chain", 32'hFFFF_FFFF, 32'h1, 1'b0, 2'b00, 32'h0,         1'b1, 1'b0, 1'b1);
    directed("sub overflow",    32'h8000_0000, 32'h1, 1'b0, 2'b01, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    directed("borrow chain",    32'h5,         32'h5, 1'b0, 2'b11, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    directed("add with cin",    32'h7,         32'h8, 1'b1, 2'b10, 32'h10,        1'b0, 1'b0, 1'b0);
    directed("sub to zero",     32'h5,         32'h5, 1'b1, 2'b01, 32'h0,         1'b1, 1'b0, 1'b1);
    directed("add overflow",    32'h7FFF_FFFF, 32'h1, 1'b0, 2'b00, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

    // T5: 8 back-to-back ops into STAGES=4, out_ready low in cycles 5-7
    sent = 0; it = 0;
    while (sent < 8 && it < 40) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = rand_operand(); b = rand_operand();
      cin = 1'($urandom_range(0, 1)); op = 2'($urandom_range(0, 3));
      out_ready[0] = !(it >= 4 && it <= 6);
      out_ready[1] = 1'b1; out_ready[2] = 1'b1;
      it++;
      @(negedge clk);
      if (in_ready_w[0]) sent++;
    end
    check("T5 ops accepted", sent, 8);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int g = 0; g < 3; g++) out_ready[g] = 1'b1;
    repeat (12) @(posedge clk);

    // T6: three ops in flight, reset the cycle before the first would complete
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'b0; op = 2'b00;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) check($sformatf("T6 flushed[%0d] out_valid", g), out_valid_w[g], 1'b0);
    end
    directed("after flush", 32'h0000_FFFF, 32'h0001_0001, 1'b0, 2'b00, 32'h0002_0000, 1'b0, 1'b0, 1'b0);

    // Random traffic with independent backpressure per instance
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 9) < 7);
      a = rand_operand(); b = rand_operand();
      cin = 1'($urandom_range(0, 1)); op = 2'($urandom_range(0, 3));
      for (int g = 0; g < 3; g++) out_ready[g] = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int g = 0; g < 3; g++) out_ready[g] = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk); #1;
    for (int g = 0; g < 3; g++) check($sformatf("drain[%0d] pending", g), qlen[g], 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
